// File: rtl/data_sram_like_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_like_resp_pkg
// Description : Shared encodings, queue-entry layout and LFSR constants for the
//               data-side SRAM-like responder.
// Revision    : 1.0 - initial release
// ============================================================================
package data_sram_like_resp_pkg;

  localparam logic [1:0] DSRAM_SIZE_B = 2'd0;
  localparam logic [1:0] DSRAM_SIZE_H = 2'd1;
  localparam logic [1:0] DSRAM_SIZE_W = 2'd2;

  // Countdown width covers LAT-1 plus up to 3 extra random cycles.
  localparam int unsigned DSRAM_CNT_W   = 8;
  localparam int unsigned DSRAM_ENTRY_W = 32 + DSRAM_CNT_W;

  localparam logic [15:0] DSRAM_LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] DSRAM_LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [31:0]            data;
    logic [DSRAM_CNT_W-1:0] cnt;
  } dsram_entry_t;

  function automatic logic [15:0] dsram_lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & DSRAM_LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_like_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_like_resp_if
// Description : Data-side SRAM-like bus bundle with requester/responder views.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_sram_like_resp_if;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

endinterface
`default_nettype wire

// File: rtl/dsram_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dsram_resp_fifo
// Description : In-order response queue; every entry counts down and the head
//               retires into a registered data_ok/rdata pair.
// Revision    : 1.0 - initial release
// ============================================================================
module dsram_resp_fifo
  import data_sram_like_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         i_push,
  input  wire dsram_entry_t i_push_entry,
  output logic              o_full,
  output logic              o_data_ok,
  output logic [31:0]       o_rdata
);

  localparam int PTR_W = $clog2(DEPTH);

  dsram_entry_t     r_q [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic w_empty;
  logic w_retire;
  logic w_bypass;
  logic w_store;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  // The output register is the last latency stage, so the head leaves one
  // count early; a zero-count push into an empty queue skips storage.
  assign w_retire = !w_empty && (r_q[r_head].cnt <= DSRAM_CNT_W'(1));
  assign w_bypass = i_push && w_empty && (i_push_entry.cnt == '0);
  assign w_store  = i_push && !w_bypass;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      o_data_ok <= 1'b0;
      o_rdata   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_q[i].cnt != '0) begin
          r_q[i].cnt <= r_q[i].cnt - 1'b1;
        end
      end
      if (w_store) begin
        r_q[r_tail] <= i_push_entry;
        r_tail      <= r_tail + 1'b1;
      end
      if (w_retire) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_store, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      o_data_ok <= w_retire | w_bypass;
      if (w_retire) begin
        o_rdata <= r_q[r_head].data;
      end else if (w_bypass) begin
        o_rdata <= i_push_entry.data;
      end else begin
        o_rdata <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_sram_like_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_like_resp
// Description : Data-side SRAM-like responder: word memory, accept logic and an
//               in-order fixed-latency response queue.
//               Optional DSRAM_RESP_RAND_DELAY_EN adds LFSR-driven jitter.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_like_resp
  import data_sram_like_resp_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4,
  parameter int LAT    = 2
) (
  input wire logic              clk,
  input wire logic              reset,
  data_sram_like_resp_if.slave  dsram
);

  logic [31:0]            r_mem [2**ADDR_W];
  logic                   w_full;
  logic                   w_gate;
  logic                   w_accept;
  logic [ADDR_W-1:0]      w_idx;
  logic [DSRAM_CNT_W-1:0] w_cnt;
  dsram_entry_t           w_entry;
  logic                   w_unused;

`ifdef DSRAM_RESP_RAND_DELAY_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= DSRAM_LFSR_SEED;
    end else begin
      r_lfsr <= dsram_lfsr_next(r_lfsr);
    end
  end

  assign w_gate = (r_lfsr[4:2] != 3'b000);
  assign w_cnt  = DSRAM_CNT_W'(LAT - 1) + DSRAM_CNT_W'(r_lfsr[1:0]);
`else
  assign w_gate = 1'b1;
  assign w_cnt  = DSRAM_CNT_W'(LAT - 1);
`endif

  // Derived only from registered occupancy so data_ok never feeds addr_ok.
  assign dsram.data_sram_addr_ok = !reset && !w_full && w_gate;

  assign w_accept = dsram.data_sram_req && dsram.data_sram_addr_ok;
  assign w_idx    = dsram.data_sram_addr[ADDR_W+1:2];

  // Reads capture the word at accept, so a write one cycle earlier is seen.
  assign w_entry.data = dsram.data_sram_wr ? 32'h0 : r_mem[w_idx];
  assign w_entry.cnt  = w_cnt;

  always_ff @(posedge clk) begin
    if (w_accept && dsram.data_sram_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (dsram.data_sram_wstrb[k]) begin
          r_mem[w_idx][8*k +: 8] <= dsram.data_sram_wdata[8*k +: 8];
        end
      end
    end
  end

  dsram_resp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_accept),
    .i_push_entry (w_entry),
    .o_full       (w_full),
    .o_data_ok    (dsram.data_sram_data_ok),
    .o_rdata      (dsram.data_sram_rdata)
  );

  assign w_unused = ^{dsram.data_sram_size, dsram.data_sram_addr[31:ADDR_W+2],
                      dsram.data_sram_addr[1:0]};

endmodule
`default_nettype wire
